// File: rtl/tt_um_hoene_manchester_pkg.sv
// Shared definitions for the Manchester receiver: receiver states,
// pulse-width thresholds derived from the bit-length reference, and
// the clamp bounds used when the reference adapts
// (MANCHESTER_RX_ADAPT_EN).
package tt_um_hoene_manchester_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } rx_state_e;

    // Thresholds use a wide fixed width so one helper serves any CNT_W.
    // Values never exceed CNT_W+1 bits for a CNT_W-bit reference.
    localparam int TH_W = 32;

    typedef struct packed {
        logic [TH_W-1:0] q1;   // shortest acceptable half-bit pulse
        logic [TH_W-1:0] q3;   // short/long boundary
        logic [TH_W-1:0] lng;  // first width beyond a long pulse
        logic [TH_W-1:0] tmo;  // silence that counts as loss of signal
    } thresh_t;

    function automatic thresh_t calc_thresh(input logic [TH_W-1:0] bl);
        thresh_t t;
        t.q1  = bl >> 2;
        t.q3  = (bl >> 1) + (bl >> 2);
        t.lng = bl + (bl >> 1);
        t.tmo = bl << 1;
        return t;
    endfunction

    function automatic int bl_clamp_lo(input int bit_length);
        return bit_length / 2;
    endfunction

    function automatic int bl_clamp_hi(input int bit_length);
        return 2 * bit_length;
    endfunction

endpackage

// File: rtl/tt_um_hoene_manchester_sync.sv
// Two-flop synchroniser for the asynchronous line, followed by a
// registered edge detector. prev_o is the line level before the edge.
module tt_um_hoene_manchester_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic edge_o,
    output logic prev_o
);

    logic s1_q, s2_q, dly_q, edge_q, prev_q;

    // Synchronise, keep a delayed copy and register the edge decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= line_i;
            s2_q   <= s1_q;
            dly_q  <= s2_q;
            edge_q <= s2_q ^ dly_q;
            prev_q <= dly_q;
        end
    end

    assign edge_o = edge_q;
    assign prev_o = prev_q;

endmodule

// File: rtl/tt_um_hoene_manchester_rx.sv
// Manchester receiver top: classifies pulse widths against a bit-length
// reference, decodes bits, assembles DATA_W-bit words (MSB first) and
// hands them out over valid/ready. Reports lock, errors and overruns.
// Define MANCHESTER_RX_ADAPT_EN to let the reference track the bit rate.
module tt_um_hoene_manchester_rx #(
    parameter int BIT_LENGTH = 24,
    parameter int CNT_W      = 8,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_word,
    output logic              out_valid,
    output logic              out_bit,
    output logic              out_bit_valid,
    output logic              out_locked,
    output logic              out_error,
    output logic              out_overrun,
    output logic [CNT_W-1:0]  out_pulsewidth
);

    import tt_um_hoene_manchester_pkg::*;

    localparam int BC_W = $clog2(DATA_W);

    logic              edge_w, prev_w;
    logic [CNT_W-1:0]  cnt_q, cnt_d, bl;
    logic              seen_q;
    rx_state_e         state_q;
    logic              middle_q;
    logic [BC_W-1:0]   bitcnt_q, bit_base, bit_next;
    logic [DATA_W-1:0] shift_q, word_new;
    logic [DATA_W-1:0] out_word_q;
    logic              out_valid_q, out_bit_q, out_bit_valid_q;
    logic              out_error_q, out_overrun_q;
    logic [CNT_W-1:0]  pulsewidth_q;

    thresh_t           th;
    logic [TH_W-1:0]   pw;
    logic              locked, is_long, is_short, emit, err, word_done;

    tt_um_hoene_manchester_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (in),
        .edge_o (edge_w),
        .prev_o (prev_w)
    );

`ifdef MANCHESTER_RX_ADAPT_EN
    localparam logic signed [CNT_W:0] BL_MIN = (CNT_W+1)'(bl_clamp_lo(BIT_LENGTH));
    localparam logic signed [CNT_W:0] BL_MAX = (CNT_W+1)'(bl_clamp_hi(BIT_LENGTH));

    logic [CNT_W-1:0]    bl_q, bl_d;
    logic signed [CNT_W:0] bl_diff, bl_sum;

    // Move the reference 1/8 of the way toward each accepted long pulse
    always_comb begin
        bl_diff = $signed({1'b0, cnt_q}) - $signed({1'b0, bl_q});
        bl_sum  = $signed({1'b0, bl_q}) + (bl_diff >>> 3);
        bl_d    = bl_q;
        if (is_long) begin
            if (bl_sum < BL_MIN)      bl_d = BL_MIN[CNT_W-1:0];
            else if (bl_sum > BL_MAX) bl_d = BL_MAX[CNT_W-1:0];
            else                      bl_d = bl_sum[CNT_W-1:0];
        end
    end

    // Bit-length reference register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bl_q <= CNT_W'(BIT_LENGTH);
        else        bl_q <= bl_d;
    end

    assign bl = bl_q;
`else
    assign bl = CNT_W'(BIT_LENGTH);
`endif

    // Pulse classification and next-state helpers
    always_comb begin
        th       = calc_thresh(TH_W'(bl));
        pw       = TH_W'(cnt_q);
        locked   = (state_q == LOCKED);
        // The very first edge after reset only starts the measurement.
        is_long  = edge_w && seen_q && (pw >= th.q3) && (pw < th.lng);
        is_short = edge_w && seen_q && (pw >= th.q1) && (pw < th.q3);
        emit     = is_long || (is_short && locked && !middle_q);
        // Bad width at an edge, or silence reaching the timeout; after the
        // error the receiver is unlocked, so a long silence fires once.
        err      = locked && (edge_w ? !(is_long || is_short) : (pw >= th.tmo));
        // Acquiring lock restarts word alignment at the locking bit.
        bit_base  = locked ? bitcnt_q : '0;
        word_done = (bit_base == BC_W'(DATA_W - 1));
        bit_next  = word_done ? '0 : bit_base + BC_W'(1);
        word_new  = {shift_q[DATA_W-2:0], prev_w};
        if (edge_w)      cnt_d = CNT_W'(1);
        else if (&cnt_q) cnt_d = cnt_q;
        else             cnt_d = cnt_q + CNT_W'(1);
    end

    // Receiver FSM: lock tracking, half-bit phase, bit assembly, strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            seen_q          <= 1'b0;
            state_q         <= HUNT;
            middle_q        <= 1'b0;
            bitcnt_q        <= '0;
            shift_q         <= '0;
            out_bit_q       <= 1'b0;
            out_bit_valid_q <= 1'b0;
            out_error_q     <= 1'b0;
            pulsewidth_q    <= CNT_W'(BIT_LENGTH);
        end else begin
            cnt_q           <= cnt_d;
            out_bit_valid_q <= 1'b0;
            out_error_q     <= 1'b0;
            if (edge_w) seen_q <= 1'b1;

            if (err) begin
                state_q     <= HUNT;
                middle_q    <= 1'b0;
                bitcnt_q    <= '0;
                out_error_q <= 1'b1;
            end else if (is_long) begin
                state_q      <= LOCKED;
                middle_q     <= 1'b1;
                pulsewidth_q <= cnt_q;
            end else if (is_short && locked) begin
                middle_q <= !middle_q;
            end

            if (emit) begin
                out_bit_q       <= prev_w;
                out_bit_valid_q <= 1'b1;
                shift_q         <= word_new;
                bitcnt_q        <= bit_next;
            end
        end
    end

    // Output word register and valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_q    <= '0;
            out_valid_q   <= 1'b0;
            out_overrun_q <= 1'b0;
        end else begin
            out_overrun_q <= 1'b0;
            if (emit && word_done) begin
                if (!out_valid_q || out_ready) begin
                    out_word_q  <= word_new;
                    out_valid_q <= 1'b1;
                end else begin
                    // Pending word wins; the new one is lost.
                    out_overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_word       = out_word_q;
    assign out_valid      = out_valid_q;
    assign out_bit        = out_bit_q;
    assign out_bit_valid  = out_bit_valid_q;
    assign out_locked     = (state_q == LOCKED);
    assign out_error      = out_error_q;
    assign out_overrun    = out_overrun_q;
    assign out_pulsewidth = pulsewidth_q;

endmodule

// File: tb/tb_tt_um_hoene_manchester_rx.sv
// Bench for tt_um_hoene_manchester_rx: random and directed Manchester
// streams; a line-level reference model predicts bits, words, errors
// and overruns into queues that a separate monitor checks.
module tb_tt_um_hoene_manchester_rx;

    localparam int BL = 24;
    localparam int CW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_word;
    logic          out_valid, out_bit, out_bit_valid;
    logic          out_locked, out_error, out_overrun;
    logic [CW-1:0] out_pulsewidth;

    tt_um_hoene_manchester_rx #(.BIT_LENGTH(BL), .CNT_W(CW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (line),
        .out_ready      (out_ready),
        .out_word       (out_word),
        .out_valid      (out_valid),
        .out_bit        (out_bit),
        .out_bit_valid  (out_bit_valid),
        .out_locked     (out_locked),
        .out_error      (out_error),
        .out_overrun    (out_overrun),
        .out_pulsewidth (out_pulsewidth)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int err_exp = 0, err_seen = 0, ovr_exp = 0, ovr_seen = 0;
    bit            exp_bits[$];
    logic [DW-1:0] exp_words[$];
    logic [DW-1:0] last_word = '0;

    // Reference model state: protocol-level view of the receiver
    int            m_first, m_locked, m_middle, m_bitcnt, m_bl, m_pend;
    logic [DW-1:0] m_shift;
    int            last_t = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_first = 1; m_locked = 0; m_middle = 0; m_bitcnt = 0;
        m_bl = BL; m_pend = 0; m_shift = '0;
    endtask

    task automatic m_lose_lock();
        err_exp++;
        m_locked = 0; m_middle = 0; m_bitcnt = 0;
    endtask

    task automatic m_emit(input bit b);
        exp_bits.push_back(b);
        m_shift = {m_shift[DW-2:0], b};
        m_bitcnt++;
        if (m_bitcnt == DW) begin
            m_bitcnt = 0;
            if (m_pend != 0 && !out_ready) ovr_exp++;
            else begin
                exp_words.push_back(m_shift);
                m_pend = out_ready ? 0 : 1;
            end
        end
    endtask

    task automatic m_edge(input int pw, input bit prev);
        int q1, q3, lg, d;
        q1 = m_bl / 4;
        q3 = m_bl / 2 + m_bl / 4;
        lg = m_bl + m_bl / 2;
        if (m_first != 0) begin
            m_first = 0;
        end else if (pw >= q3 && pw < lg) begin
            if (m_locked == 0) m_bitcnt = 0;
            m_locked = 1;
            m_middle = 1;
            m_emit(prev);
`ifdef MANCHESTER_RX_ADAPT_EN
            d = (pw - m_bl) >>> 3;
            m_bl = m_bl + d;
            if (m_bl < BL / 2) m_bl = BL / 2;
            if (m_bl > 2 * BL) m_bl = 2 * BL;
`else
            d = 0;
`endif
        end else if (pw >= q1 && pw < q3) begin
            if (m_locked != 0) begin
                if (m_middle == 0) m_emit(prev);
                m_middle = (m_middle == 0) ? 1 : 0;
            end
        end else if (m_locked != 0) begin
            m_lose_lock();
        end
    endtask

    // Inputs change just after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input logic v);
        if (v !== line) begin
            m_edge(cyc - last_t, line);
            line = v;
            last_t = cyc;
        end
    endtask

    task automatic idle(input int n);
        tick(n);
        if (m_locked != 0 && (cyc - last_t) >= 2 * m_bl) m_lose_lock();
    endtask

    // First half carries the bit value, second half its complement
    task automatic send_bit(input bit b, input int h1, input int h2);
        set_line(b);
        tick(h1);
        set_line(!b);
        tick(h2);
    endtask

    task automatic send_byte(input logic [DW-1:0] v, input int h);
        for (int i = DW - 1; i >= 0; i--) send_bit(v[i], h, h);
    endtask

    // 0,1,0,...: locks on the second bit, which then starts a word
    task automatic preamble(input int h);
        for (int i = 0; i < DW + 1; i++) send_bit(bit'(i % 2), h, h);
    endtask

    task automatic send_rand(input int n, input int h, input int j);
        for (int i = 0; i < n; i++) begin
            int h1, h2;
            h1 = h + int'($urandom_range(2 * j)) - j;
            h2 = h + int'($urandom_range(2 * j)) - j;
            send_bit(bit'($urandom_range(1)), h1, h2);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_word"},     out_word, 0);
        chk({p, "_valid"},    out_valid, 0);
        chk({p, "_bit"},      out_bit, 0);
        chk({p, "_bitvalid"}, out_bit_valid, 0);
        chk({p, "_locked"},   out_locked, 0);
        chk({p, "_error"},    out_error, 0);
        chk({p, "_overrun"},  out_overrun, 0);
        chk({p, "_pw"},       out_pulsewidth, BL);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues
    initial begin : monitor
        logic          hold_prev;
        logic [DW-1:0] held;
        hold_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_bit_valid) begin
                    if (exp_bits.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL bit: strobe with value %0d, none required", out_bit);
                    end else chk("bit", out_bit, exp_bits.pop_front());
                end
                if (hold_prev && out_valid) chk("word_stable", out_word, held);
                if (out_valid && out_ready) begin
                    if (exp_words.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL word: transfer of %0d, none required", out_word);
                    end else chk("word", out_word, exp_words.pop_front());
                    last_word = out_word;
                end
                if (out_error) err_seen++;
                if (out_overrun) ovr_seen++;
                hold_prev = out_valid && !out_ready;
                held = out_word;
            end else hold_prev = 1'b0;
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0, o0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        last_t = cyc;
        tick(5);

        // Lock on an alternating preamble, then 0xA5
        out_ready = 1'b1;
        preamble(12);
        chk("lock_locked", out_locked, 1);
        chk("lock_pw", out_pulsewidth, 24);
        chk("lock_no_error", err_seen, 0);
        send_byte(8'hA5, 12);
        chk("word_A5", last_word, 8'hA5);

        // Overrun: 0x3C held, 0x81 dropped
        out_ready = 1'b0;
        o0 = ovr_seen;
        send_byte(8'h3C, 12);
        send_byte(8'h81, 12);
        chk("ovr_valid", out_valid, 1);
        chk("ovr_word", out_word, 8'h3C);
        chk("ovr_once", ovr_seen - o0, 1);
        out_ready = 1'b1;
        m_pend = 0;
        tick(1);
        chk("ovr_cleared", out_valid, 0);
        chk("ovr_delivered", last_word, 8'h3C);

        // Timeout: line held ~50 clocks, then an unlocked 5-clock glitch
        e0 = err_seen;
        idle(37);
        tick(5);
        chk("tmo_error", err_seen - e0, 1);
        chk("tmo_unlocked", out_locked, 0);
        set_line(!line);
        tick(5);
        set_line(!line);
        tick(20);
        chk("glitch_no_error", err_seen - e0, 1);
        chk("glitch_unlocked", out_locked, 0);

        // 28 clocks per bit still decodes
        preamble(14);
        send_rand(16, 14, 0);
        chk("slow28_locked", out_locked, 1);
        chk("slow28_pw", out_pulsewidth, 28);
        idle(60);

        // 40 clocks per bit: full-bit pulses are out of range
        preamble(12);
        e0 = err_seen;
        send_byte(8'h3A, 20);
        chk("slow40_error", err_seen > e0, 1);
        idle(60);

        // Random jittered streams, ready held low in some rounds
        for (int r = 0; r < 4; r++) begin
            out_ready = (r % 2 == 0);
            preamble(12);
            send_rand(40, 12, 2);
            idle(60);
            out_ready = 1'b1;
            m_pend = 0;
            tick(2);
        end

        // Asynchronous reset mid-word with a pending word
        out_ready = 1'b0;
        preamble(12);
        send_byte(8'h5A, 12);
        send_bit(1'b1, 12, 12);
        send_bit(1'b0, 12, 6);
        chk("prerst_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        line = 1'b0;
        #1;
        chk_reset("midrst");
        exp_bits.delete();
        exp_words.delete();
        m_reset();
        tick(2);
        rst_n = 1'b1;
        last_t = cyc;
        tick(5);
        chk("restart_unlocked", out_locked, 0);
        out_ready = 1'b1;
        preamble(12);
        send_byte(8'hC3, 12);
        chk("restart_word", last_word, 8'hC3);
        idle(60);
        tick(10);

        chk("bits_drained", exp_bits.size(), 0);
        chk("words_drained", exp_words.size(), 0);
        chk("error_count", err_seen, err_exp);
        chk("overrun_count", ovr_seen, ovr_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
